// File: rtl/dropout_pkg.sv
// Shared constants, FSM encoding and LFSR helper for the dropout mask generator.
// The LFSR is a 16-bit right-shifting Galois LFSR for x^16+x^14+x^13+x^11+1.
package dropout_pkg;

    localparam int                  LFSR_W       = 16;
    localparam logic [LFSR_W-1:0]   LFSR_TAPS    = 16'hB400;
    localparam logic [LFSR_W-1:0]   DEFAULT_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GEN   = 2'd1,
        VALID = 2'd2
    } state_t;

    // Eight Galois steps: every lane sees a completely fresh low byte.
    function automatic logic [LFSR_W-1:0] lfsr_advance8(input logic [LFSR_W-1:0] s);
        logic [LFSR_W-1:0] v;
        v = s;
        for (int i = 0; i < 8; i++) begin
            v = v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
        end
        return v;
    endfunction

endpackage

// File: rtl/dropout_mask_gen_lfsr.sv
// Registered 16-bit Galois LFSR with seed load and advance-by-8 enable.
// A zero load value is replaced by the reset seed so the LFSR never locks up.
module lfsr16_galois
    import dropout_pkg::*;
#(
    parameter logic [LFSR_W-1:0] RESET_SEED = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_value,
    input  logic              adv,
    output logic [7:0]        lane_byte
);

    logic [LFSR_W-1:0] lfsr_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_reg <= RESET_SEED;
        end else if (load) begin
            lfsr_reg <= (load_value == '0) ? RESET_SEED : load_value;
        end else if (adv) begin
            lfsr_reg <= lfsr_advance8(lfsr_reg);
        end
    end

    assign lane_byte = lfsr_reg[7:0];

endmodule

// File: rtl/dropout_mask_gen.sv
// Builds an N-lane keep/drop mask one lane per cycle from the LFSR low byte,
// then holds it behind a valid/ready handshake for the RandomDropout stage.
module dropout_mask_gen #(
    parameter int          N            = 8,
    parameter logic [15:0] DEFAULT_SEED = dropout_pkg::DEFAULT_SEED
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 seed_load,
    input  logic [15:0]          seed,
    input  logic [7:0]           drop_rate,
    output logic [N-1:0]         mask,
    output logic                 mask_valid,
    input  logic                 mask_ready,
    output logic [$clog2(N+1)-1:0] drop_count
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(N+1);

    dropout_pkg::state_t state_reg;
    logic [IW-1:0]       idx_reg;
    logic [7:0]          rate_reg;
    logic [N-1:0]        mask_reg;
    logic [N-1:0]        mask_gen_next;
    logic [CW-1:0]       drop_count_reg;
    logic                mask_valid_reg;
    logic [7:0]          lane_byte;
    logic                lane_keep;
    logic                lfsr_adv;

    assign lfsr_adv  = (state_reg == dropout_pkg::GEN) && ena && !seed_load;
    assign lane_keep = (lane_byte >= rate_reg);

    lfsr16_galois #(
        .RESET_SEED (DEFAULT_SEED)
    ) u_lfsr (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (seed_load),
        .load_value (seed),
        .adv        (lfsr_adv),
        .lane_byte  (lane_byte)
    );

    // Only the lane selected by idx takes the new decision; others keep their bit.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_lane
            assign mask_gen_next[gi] = (idx_reg == IW'(gi)) ? lane_keep : mask_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= dropout_pkg::IDLE;
            idx_reg        <= '0;
            rate_reg       <= '0;
            mask_reg       <= '1;
            drop_count_reg <= '0;
            mask_valid_reg <= 1'b0;
        end else if (seed_load) begin
            state_reg      <= dropout_pkg::IDLE;
            idx_reg        <= '0;
            mask_reg       <= '1;
            drop_count_reg <= '0;
            mask_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                dropout_pkg::IDLE: begin
                    if (ena) begin
                        state_reg      <= dropout_pkg::GEN;
                        rate_reg       <= drop_rate;
                        idx_reg        <= '0;
                        mask_reg       <= '1;
                        drop_count_reg <= '0;
                    end
                end
                dropout_pkg::GEN: begin
                    if (ena) begin
                        mask_reg <= mask_gen_next;
                        if (!lane_keep) begin
                            drop_count_reg <= drop_count_reg + CW'(1);
                        end
                        if (idx_reg == IW'(N-1)) begin
                            state_reg      <= dropout_pkg::VALID;
                            mask_valid_reg <= 1'b1;
                            idx_reg        <= '0;
                        end else begin
                            idx_reg <= idx_reg + IW'(1);
                        end
                    end
                end
                dropout_pkg::VALID: begin
                    // The handshake is honoured regardless of ena; ena only picks the next state.
                    if (mask_ready) begin
                        mask_valid_reg <= 1'b0;
                        if (ena) begin
                            state_reg      <= dropout_pkg::GEN;
                            rate_reg       <= drop_rate;
                            idx_reg        <= '0;
                            mask_reg       <= '1;
                            drop_count_reg <= '0;
                        end else begin
                            state_reg <= dropout_pkg::IDLE;
                        end
                    end
                end
                default: begin
                    state_reg <= dropout_pkg::IDLE;
                end
            endcase
        end
    end

    assign mask       = mask_reg;
    assign mask_valid = mask_valid_reg;
    assign drop_count = drop_count_reg;

endmodule

// File: tb/tb_dropout_mask_gen.sv
// Self-checking bench for dropout_mask_gen: randomized stimulus against a lane-by-lane
// reference model of the LFSR sequence and the keep/drop rule.
module tb_dropout_mask_gen;

    localparam int N = 8;

    logic        clk        = 1'b0;
    logic        rst_n      = 1'b0;
    logic        ena        = 1'b0;
    logic        seed_load  = 1'b0;
    logic [15:0] seed       = '0;
    logic [7:0]  drop_rate  = '0;
    logic        mask_ready = 1'b0;
    logic [7:0]  mask;
    logic        mask_valid;
    logic [3:0]  drop_count;

    int          checks = 0;
    int          fails  = 0;
    int unsigned m_lfsr;

    dropout_mask_gen #(
        .N            (N),
        .DEFAULT_SEED (16'hACE1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .seed_load  (seed_load),
        .seed       (seed),
        .drop_rate  (drop_rate),
        .mask       (mask),
        .mask_valid (mask_valid),
        .mask_ready (mask_ready),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n      = 1'b0;
        ena        = 1'b0;
        seed_load  = 1'b0;
        mask_ready = 1'b0;
        #3;
        tick;
        rst_n  = 1'b1;
        m_lfsr = 32'hACE1;
    endtask

    function automatic int unsigned lfsr_next(input int unsigned s);
        return (s & 1) ? ((s >> 1) ^ 32'hB400) : (s >> 1);
    endfunction

    // Reference: lane i keeps iff the current low byte >= rate, then the LFSR moves 8 steps.
    task automatic model_mask(input int rate, output logic [7:0] m, output int dc);
        int b;
        dc = 0;
        m  = '1;
        for (int lane = 0; lane < N; lane++) begin
            b = int'(m_lfsr & 32'hFF);
            m[lane] = (b >= rate);
            if (b < rate) dc++;
            for (int s = 0; s < 8; s++) m_lfsr = lfsr_next(m_lfsr);
        end
    endtask

    task automatic wait_valid(input int budget, output int n);
        n = 0;
        while (!mask_valid && n < budget) begin
            tick;
            n++;
        end
        if (!mask_valid) n = -1;
    endtask

    task automatic test_reset;
        do_reset;
        checks++; if (mask_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", mask_valid); end
        checks++; if (mask !== 8'hFF) begin fails++; $display("FAIL reset_mask: got %h want ff", mask); end
        checks++; if (drop_count !== 4'd0) begin fails++; $display("FAIL reset_dc: got %0d want 0", drop_count); end
        checks++; if (dut.u_lfsr.lfsr_reg !== 16'hACE1) begin fails++; $display("FAIL reset_lfsr: got %h want ace1", dut.u_lfsr.lfsr_reg); end
        drop_rate = 8'd128;
        ena       = 1'b1;
        repeat (5) tick;
        checks++; if (dut.state_reg !== dropout_pkg::GEN) begin fails++; $display("FAIL midgen_state: got %0d want GEN", dut.state_reg); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (mask_valid !== 1'b0) begin fails++; $display("FAIL async_rst_valid: got %b want 0", mask_valid); end
        checks++; if (mask !== 8'hFF) begin fails++; $display("FAIL async_rst_mask: got %h want ff", mask); end
        checks++; if (drop_count !== 4'd0) begin fails++; $display("FAIL async_rst_dc: got %0d want 0", drop_count); end
        checks++; if (dut.u_lfsr.lfsr_reg !== 16'hACE1) begin fails++; $display("FAIL async_rst_lfsr: got %h want ace1", dut.u_lfsr.lfsr_reg); end
        checks++; if (dut.state_reg !== dropout_pkg::IDLE) begin fails++; $display("FAIL async_rst_state: got %0d want IDLE", dut.state_reg); end
        ena = 1'b0;
        #2 rst_n = 1'b1;
        $display("reset: async reset mid-GEN returned outputs to reset values");
    endtask

    task automatic test_rate_zero;
        logic [7:0] em;
        int         edc;
        int         n;
        do_reset;
        drop_rate  = 8'd0;
        ena        = 1'b1;
        mask_ready = 1'b1;
        wait_valid(50, n);
        checks++; if (n != 9) begin fails++; $display("FAIL rz_latency: got %0d edges want 9", n); end
        for (int k = 0; k < 5; k++) begin
            model_mask(0, em, edc);
            checks++; if (mask !== 8'hFF || mask !== em) begin fails++; $display("FAIL rz_mask%0d: got %h want ff", k, mask); end
            checks++; if (int'(drop_count) != edc || drop_count !== 4'd0) begin fails++; $display("FAIL rz_dc%0d: got %0d want 0", k, drop_count); end
            $display("rate0 mask %0d: mask=%h drops=%0d", k, mask, drop_count);
            if (k < 4) begin
                tick;
                checks++; if (mask_valid !== 1'b0) begin fails++; $display("FAIL rz_pulse%0d: valid got %b want 0", k, mask_valid); end
                wait_valid(50, n);
                checks++; if (n + 1 != 9) begin fails++; $display("FAIL rz_period%0d: got %0d want 9", k, n + 1); end
            end
        end
        checks++; if (dut.u_lfsr.lfsr_reg !== 16'(m_lfsr)) begin fails++; $display("FAIL rz_lfsr: got %h want %h", dut.u_lfsr.lfsr_reg, 16'(m_lfsr)); end
        mask_ready = 1'b0;
        ena        = 1'b0;
    endtask

    task automatic test_reference;
        logic [7:0] em;
        int         edc;
        int         n;
        int         drops;
        drops = 0;
        do_reset;
        seed      = 16'h1234;
        seed_load = 1'b1;
        tick;
        seed_load = 1'b0;
        m_lfsr    = 32'h1234;
        checks++; if (dut.u_lfsr.lfsr_reg !== 16'h1234) begin fails++; $display("FAIL ref_seed: got %h want 1234", dut.u_lfsr.lfsr_reg); end
        drop_rate = 8'd128;
        for (int k = 0; k < 100; k++) begin
            mask_ready = 1'b0;
            n = 0;
            while (!mask_valid && n < 200) begin
                ena = ($urandom_range(0, 3) != 0);
                tick;
                n++;
            end
            checks++;
            if (!mask_valid) begin
                fails++;
                $display("FAIL ref_timeout%0d: valid got 0 want 1", k);
            end else begin
                model_mask(128, em, edc);
                drops += edc;
                checks++; if (mask !== em) begin fails++; $display("FAIL ref_mask%0d: got %h want %h", k, mask, em); end
                checks++; if (int'(drop_count) != edc) begin fails++; $display("FAIL ref_dc%0d: got %0d want %0d", k, drop_count, edc); end
                $display("ref mask %0d: mask=%h drops=%0d", k, mask, drop_count);
            end
            mask_ready = 1'b1;
            ena        = 1'($urandom_range(0, 1));
            tick;
            mask_ready = 1'b0;
            checks++; if (mask_valid !== 1'b0) begin fails++; $display("FAIL ref_handshake%0d: valid got %b want 0", k, mask_valid); end
        end
        checks++; if (drops < 320 || drops > 480) begin fails++; $display("FAIL ref_ratio: got %0d drops want 320..480 of 800", drops); end
        ena = 1'b0;
    endtask

    task automatic test_zero_seed;
        int         rates[3];
        logic [7:0] rec_mask[3];
        int         rec_dc[3];
        logic [7:0] em;
        int         edc;
        int         n;
        rates = '{100, 200, 50};
        do_reset;
        for (int k = 0; k < 3; k++) begin
            drop_rate = 8'(rates[k]);
            ena = 1'b1;
            wait_valid(50, n);
            checks++; if (n < 0) begin fails++; $display("FAIL zs_timeout_a%0d: valid got 0 want 1", k); end
            model_mask(rates[k], em, edc);
            rec_mask[k] = mask;
            rec_dc[k]   = int'(drop_count);
            checks++; if (mask !== em) begin fails++; $display("FAIL zs_model%0d: got %h want %h", k, mask, em); end
            mask_ready = 1'b1;
            ena        = 1'b0;
            tick;
            mask_ready = 1'b0;
        end
        seed      = 16'h0000;
        seed_load = 1'b1;
        tick;
        seed_load = 1'b0;
        checks++; if (dut.u_lfsr.lfsr_reg !== 16'hACE1) begin fails++; $display("FAIL zs_lfsr: got %h want ace1", dut.u_lfsr.lfsr_reg); end
        for (int k = 0; k < 3; k++) begin
            drop_rate = 8'(rates[k]);
            ena = 1'b1;
            wait_valid(50, n);
            checks++; if (n < 0) begin fails++; $display("FAIL zs_timeout_b%0d: valid got 0 want 1", k); end
            checks++; if (mask !== rec_mask[k]) begin fails++; $display("FAIL zs_mask%0d: got %h want %h", k, mask, rec_mask[k]); end
            checks++; if (int'(drop_count) != rec_dc[k]) begin fails++; $display("FAIL zs_dc%0d: got %0d want %0d", k, drop_count, rec_dc[k]); end
            $display("zero-seed mask %0d: mask=%h drops=%0d", k, mask, drop_count);
            mask_ready = 1'b1;
            ena        = 1'b0;
            tick;
            mask_ready = 1'b0;
        end
    endtask

    task automatic test_back_pressure;
        logic [7:0]  em;
        int          edc;
        int          n;
        logic [7:0]  held_mask;
        logic [3:0]  held_dc;
        logic [15:0] held_lfsr;
        do_reset;
        drop_rate = 8'd77;
        ena       = 1'b1;
        wait_valid(50, n);
        checks++; if (n < 0) begin fails++; $display("FAIL bp_timeout: valid got 0 want 1"); end
        model_mask(77, em, edc);
        checks++; if (mask !== em) begin fails++; $display("FAIL bp_mask: got %h want %h", mask, em); end
        held_mask = em;
        held_dc   = 4'(edc);
        held_lfsr = 16'(m_lfsr);
        for (int c = 0; c < 20; c++) begin
            ena = 1'($urandom_range(0, 1));
            tick;
            checks++;
            if (mask_valid !== 1'b1 || mask !== held_mask || drop_count !== held_dc || dut.u_lfsr.lfsr_reg !== held_lfsr) begin
                fails++;
                $display("FAIL bp_hold%0d: got v=%b m=%h dc=%0d l=%h want v=1 m=%h dc=%0d l=%h",
                         c, mask_valid, mask, drop_count, dut.u_lfsr.lfsr_reg, held_mask, held_dc, held_lfsr);
            end
        end
        drop_rate  = 8'd33;
        ena        = 1'b1;
        mask_ready = 1'b1;
        tick;
        mask_ready = 1'b0;
        checks++; if (dut.state_reg !== dropout_pkg::GEN) begin fails++; $display("FAIL bp_state: got %0d want GEN", dut.state_reg); end
        checks++; if (mask_valid !== 1'b0) begin fails++; $display("FAIL bp_valid: got %b want 0", mask_valid); end
        wait_valid(50, n);
        model_mask(33, em, edc);
        checks++; if (mask !== em || int'(drop_count) != edc) begin fails++; $display("FAIL bp_next: got %h/%0d want %h/%0d", mask, drop_count, em, edc); end
        $display("backpressure: held mask=%h, next mask=%h drops=%0d", held_mask, mask, drop_count);
        ena = 1'b0;
    endtask

    task automatic test_abort;
        logic [7:0] em;
        int         edc;
        int         n;
        do_reset;
        drop_rate = 8'd200;
        ena       = 1'b1;
        repeat (5) tick;
        drop_rate = 8'd10;
        checks++; if (dut.idx_reg !== 3'd4) begin fails++; $display("FAIL ab_idx: got %0d want 4", dut.idx_reg); end
        seed      = 16'h5A5A;
        seed_load = 1'b1;
        tick;
        seed_load = 1'b0;
        m_lfsr    = 32'h5A5A;
        checks++; if (dut.state_reg !== dropout_pkg::IDLE) begin fails++; $display("FAIL ab_state: got %0d want IDLE", dut.state_reg); end
        checks++; if (mask !== 8'hFF) begin fails++; $display("FAIL ab_mask: got %h want ff", mask); end
        checks++; if (mask_valid !== 1'b0 || drop_count !== 4'd0) begin fails++; $display("FAIL ab_clear: got v=%b dc=%0d want v=0 dc=0", mask_valid, drop_count); end
        checks++; if (dut.u_lfsr.lfsr_reg !== 16'h5A5A) begin fails++; $display("FAIL ab_lfsr: got %h want 5a5a", dut.u_lfsr.lfsr_reg); end
        drop_rate = 8'd60;
        tick;
        repeat (2) tick;
        drop_rate = 8'd250;
        wait_valid(50, n);
        checks++; if (n < 0) begin fails++; $display("FAIL ab_timeout: valid got 0 want 1"); end
        model_mask(60, em, edc);
        checks++; if (mask !== em) begin fails++; $display("FAIL ab_next_mask: got %h want %h", mask, em); end
        checks++; if (int'(drop_count) != edc) begin fails++; $display("FAIL ab_next_dc: got %0d want %0d", drop_count, edc); end
        $display("abort: mask after reseed=%h drops=%0d", mask, drop_count);
        ena = 1'b0;
    endtask

    task automatic test_rate_boundaries;
        int         rl[8];
        logic [7:0] em;
        int         edc;
        int         n;
        rl = '{255, 255, 254, 1, 0, 0, 0, 0};
        for (int i = 4; i < 8; i++) rl[i] = int'($urandom_range(0, 255));
        do_reset;
        drop_rate = 8'(rl[0]);
        ena       = 1'b1;
        for (int k = 0; k < 8; k++) begin
            wait_valid(50, n);
            checks++; if (n < 0) begin fails++; $display("FAIL rb_timeout%0d: valid got 0 want 1", k); end
            model_mask(rl[k], em, edc);
            checks++; if (mask !== em) begin fails++; $display("FAIL rb_mask%0d: rate %0d got %h want %h", k, rl[k], mask, em); end
            checks++; if (int'(drop_count) != edc) begin fails++; $display("FAIL rb_dc%0d: rate %0d got %0d want %0d", k, rl[k], drop_count, edc); end
            $display("rate %0d mask %0d: mask=%h drops=%0d", rl[k], k, mask, drop_count);
            if (k < 7) begin
                drop_rate  = 8'(rl[k+1]);
                mask_ready = 1'b1;
                tick;
                mask_ready = 1'b0;
            end
        end
        ena = 1'b0;
    endtask

    initial begin
        test_reset;
        test_rate_zero;
        test_reference;
        test_zero_seed;
        test_back_pressure;
        test_abort;
        test_rate_boundaries;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/dropout_mask_gen.md
# dropout_mask_gen

Pseudo-random keep/drop mask generator feeding the `RandomDropout` stage, directly upstream of it. It holds a 16-bit Galois LFSR and a programmable drop rate, and builds an N-lane mask one lane per cycle. The finished mask is handed downstream over a valid/ready handshake. A `0` bit in the mask zeroes the corresponding data bit in the dropout stage.

## Interface
- `N`, default 8: number of mask lanes; matches the dropout datapath width.
- `DEFAULT_SEED`, default 16'hACE1: reset seed, and the replacement value for an all-zero seed.
- `clk` input, 1 bit: the single clock; all state changes on its rising edge.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `ena` input, 1 bit: advance enable; generation pauses while low.
- `seed_load` input, 1 bit: synchronous LFSR seed load; aborts any mask in progress.
- `seed` input, 16 bits: seed value used when `seed_load`=1.
- `drop_rate` input, 8 bits: drop probability, `drop_rate`/256; latched at the start of each mask.
- `mask` output, N bits: 1=keep, 0=drop; valid while `mask_valid`=1.
- `mask_valid` output, 1 bit: mask complete and stable.
- `mask_ready` input, 1 bit: downstream accepts the mask.
- `drop_count` output, $clog2(N+1) bits: number of 0 bits in `mask`.

## Operation
- FSM states: IDLE, GEN, VALID.
- IDLE:
  - `ena`=1: go to GEN, latch `drop_rate` into `rate_q`, set `idx`=0.
- GEN, each cycle with `ena`=1:
  - Lane decision: `mask[idx]` = (`lfsr[7:0]` >= `rate_q`). A lane is dropped iff its random byte is below `rate_q`.
  - `drop_count` increments on each drop.
  - The LFSR advances 8 Galois steps per cycle, so each lane gets a fresh byte.
  - `idx`++; after lane N-1, go to VALID.
  - Lane 0 is decided first.
- GEN with `ena`=0: all state holds, including the LFSR, `idx` and the partial mask.
- VALID:
  - `mask_valid`=1; `mask` and `drop_count` are held stable until the handshake (`mask_valid`&`mask_ready`).
  - On handshake with `ena`=1: go to GEN, relatch the rate, `idx`=0, clear `drop_count`.
  - On handshake with `ena`=0: go to IDLE.
  - `ena` does not gate the handshake itself.
- LFSR:
  - Polynomial x^16+x^14+x^13+x^11+1, Galois taps 16'hB400, shift right.
  - It advances only in GEN with `ena`=1.
- `seed_load`:
  - Has priority over everything except reset.
  - `lfsr` <= (`seed`==0 ? `DEFAULT_SEED` : `seed`).
  - State goes to IDLE, `mask_valid` drops, `idx`=0, `mask`=all ones, `drop_count`=0.
  - Applies in any state.
- Rate boundaries:
  - `drop_rate`=0: never drops, so `mask`=all ones.
  - `drop_rate`=255: drops unless the byte is 8'hFF.
  - A certain drop of every lane is not possible.
- `drop_rate` changes during GEN have no effect until the next mask.

## Timing
- Reset values: state IDLE, `lfsr`=`DEFAULT_SEED`, `mask`=all ones, `mask_valid`=0, `drop_count`=0, `rate_q`=0, `idx`=0.
- Latency: the first edge with `ena`=1 in IDLE enters GEN. `mask_valid` rises N+1 edges after that first edge (9 for N=8).
- Throughput with `ena` and `mask_ready` held high: one mask per N+1 cycles.
- `mask_valid` never drops without a handshake, except on `seed_load` or reset.
- All outputs are registered; there is no combinational path from `mask_ready` to any output.
- Reset asserted mid-GEN or mid-VALID returns all state to the reset values immediately; the partial mask is discarded.

## Structure
- Shared `dropout_pkg` contains:
  - LFSR width (16), taps 16'hB400 and `DEFAULT_SEED`.
  - FSM enum `state_t` (IDLE, GEN, VALID).
  - An `lfsr_advance8` function.
- One sub-module, `lfsr16_galois`:
  - Registered LFSR with load and advance-by-8 enable.
  - Exposes `lfsr[7:0]` to the lane comparator.
- The top level holds the FSM, `idx`, `rate_q`, the mask register and `drop_count`.

## Test plan
- Reset check: assert `rst_n`=0 mid-GEN. Required: `mask_valid`=0, `mask`=8'hFF and `drop_count`=0 at once; `lfsr`=16'hACE1.
- Rate zero: `drop_rate`=0, `ena`=1, `mask_ready`=1. Required: `mask`=8'hFF and `drop_count`=0 on every mask; `mask_valid` pulses every 9 cycles.
- Reference model: `seed_load` with `seed`=16'h1234, then `drop_rate`=128 for 100 masks. Required: every mask and `drop_count` match the bit-exact model; roughly half of all lanes are dropped.
- Zero seed: `seed_load` with `seed`=0. Required: `lfsr`=16'hACE1, and the masks that follow equal those produced after reset.
- Backpressure: `mask_ready`=0 for 20 cycles after `mask_valid` rises. Required: `mask` and `drop_count` stay stable and the LFSR does not advance; one cycle after `mask_ready`=1, state is GEN.
- Abort: `seed_load` pulsed at lane 4 of GEN, and `drop_rate` changed mid-GEN. Required: state returns to IDLE with `mask`=8'hFF; the next mask uses the new seed and the rate latched at its start.
